// File: rtl/layer4_input_buffer.sv
// Ping-pong collector: assembles N_IN streamed activation words into a parallel
// vector for the layer-4 neuron bank, filling one bank while the other is consumed.
module layer4_input_buffer #(
    parameter int N_IN  = 15,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WIDTH-1:0]        s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_IN*WIDTH-1:0]   m_data,
    output logic                    len_err
);

    localparam int IDX_W = $clog2(N_IN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    typedef enum logic {FILL, DRAIN} wr_state_t;

    wr_state_t           state_q, state_d;
    logic [WIDTH-1:0]    mem [2][N_IN];
    logic [1:0]          full_q, full_d;
    logic                wr_bank, rd_bank;
    logic [IDX_W-1:0]    index;
    logic                accept, commit, release_bank, len_err_d, at_end;

    // s_ready depends only on registered state, so m_ready never reaches it combinationally.
    assign s_ready = rst_n && ((state_q == DRAIN) || !full_q[wr_bank]);
    assign accept  = s_valid && s_ready;
    assign at_end  = (index == LAST_IDX);

    assign m_valid      = full_q[rd_bank];
    assign release_bank = full_q[rd_bank] && m_ready;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        commit    = 1'b0;
        len_err_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept && (s_last || at_end)) begin
                    commit    = 1'b1;
                    len_err_d = (s_last != at_end);
                    if (at_end && !s_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && s_last) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Commit targets wr_bank (known empty) and release targets rd_bank (known full),
    // so the two never collide and both take effect.
    always_comb begin
        full_d = full_q;
        if (commit)       full_d[wr_bank] = 1'b1;
        if (release_bank) full_d[rd_bank] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            full_q  <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            index   <= '0;
            len_err <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            len_err <= len_err_d;
            if (release_bank) rd_bank <= ~rd_bank;
            if (commit) begin
                wr_bank <= ~wr_bank;
                index   <= '0;
            end else if (accept && state_q == FILL) begin
                index <= index + 1'b1;
            end
        end
    end

    // NOTE: the banks are flops read fully in parallel, and m_data must read zero out of
    // reset, so this storage is reset like any other register rather than left as RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int j = 0; j < N_IN; j++)
                    mem[b][j] <= '0;
        end else if (accept && state_q == FILL) begin
            // First word of a vector clears the bank so short vectors pad with +0.0.
            if (index == '0)
                for (int j = 1; j < N_IN; j++)
                    mem[wr_bank][j] <= '0;
            mem[wr_bank][index] <= s_data;
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < N_IN; i++)
            m_data[WIDTH*i +: WIDTH] = mem[rd_bank][i];
    end

endmodule

// File: doc/layer4_input_buffer.md
# layer4_input_buffer

Ping-pong input collector that sits directly upstream of the layer-4 neuron bank. It receives layer-3 activations as a stream of IEEE-754 single-precision words, one per cycle, under a valid/ready handshake. It assembles each group of N_IN words into a parallel vector and holds that vector stable on A0x..A14x-ordered slices for the combinational layer-4 nodes. Two banks let the next vector fill while the current one is being consumed.

## Interface
- N_IN, 15, words per activation vector (one per layer-4 node input)
- WIDTH, 32, word width (IEEE-754 single)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  upstream word valid
- s_ready  output  1  buffer can accept a word this cycle
- s_data  input  WIDTH  activation word
- s_last  input  1  marks final word of a vector
- m_valid  output  1  complete vector presented on m_data
- m_ready  input  1  layer-4 consumer has taken the vector
- m_data  output  N_IN*WIDTH  word i at bits [WIDTH*i+WIDTH-1 : WIDTH*i], i.e. slice 0 feeds A0x
- len_err  output  1  one-cycle pulse: vector length mismatch with s_last

## Operation
- State: two banks of N_IN words, full[1:0], wr_bank, rd_bank, index counter (0..N_IN-1), write FSM {FILL, DRAIN}.
- Word accepted when s_valid && s_ready. It is written to bank wr_bank at position index, and index increments.
- s_ready = (FSM==DRAIN) || !full[wr_bank]; forced 0 while rst_n low. It is a function of registers only, with no combinational path from m_ready.
- Bank commit, FILL:
  - Accepted word with s_last at index N_IN-1: set full[wr_bank], toggle wr_bank, index←0.
  - s_last at index < N_IN-1 (short): commit as above. Unwritten positions read +0.0 (32'h0). len_err pulses.
  - Word at index N_IN-1 without s_last (long): commit as above, len_err pulses, FSM→DRAIN.
- DRAIN: accepted words are discarded and index is held at 0. When a word with s_last is accepted, FSM→FILL. In DRAIN, s_ready=1 regardless of bank state.
- Each bank is zeroed when its first word (index 0) is written, so stale data never leaks into a short vector.
- Read side: m_valid = full[rd_bank]; m_data = bank rd_bank. On m_valid && m_ready: clear full[rd_bank], toggle rd_bank.
- Commit and release in the same cycle act on different banks, and both take effect.
- Vectors are delivered strictly in arrival order. No word is ever overwritten while its bank is full.

## Timing
- Reset (async assert, sync-safe release):
  - m_valid=0, m_data=0, len_err=0, full=00, wr_bank=rd_bank=0, index=0, FSM=FILL.
  - s_ready=0 during reset and 1 in the first cycle after release.
- Latency: the last word is accepted at edge k, and m_valid=1 with data stable from after edge k.
- m_data is stable for the whole time m_valid is high. It changes only after a handshake edge.
- Release at edge k frees the bank; s_ready can rise after edge k.
- Throughput: one word per cycle sustained while m_ready=1. With m_ready=0, exactly 2·N_IN words are accepted before s_ready drops.
- len_err is registered and asserts for exactly the one cycle following the offending acceptance edge.
- rst_n asserted mid-fill or mid-drain discards all partial and held vectors immediately.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → m_valid=0, m_data=0, len_err=0, and s_ready=1 in the first cycle after release.
- Nominal vector: 15 words 32'h3F800000+i, s_last on i=14, m_ready=1 → m_valid high the cycle after the 15th acceptance, slice i=32'h3F800000+i, one handshake, then m_valid=0.
- Backpressure: m_ready=0, stream 3 vectors → s_ready falls after word 30 and vector 3 stalls. Raise m_ready for 1 cycle → vector 1 released, s_ready=1 next cycle, vectors 2 then 3 delivered in order.
- Short vector: s_last on word 5 (index 4) → slices 0..4 hold data, slices 5..14 = 32'h0, len_err one-cycle pulse. Next vector starts at index 0.
- Long vector: 17 words, s_last on word 17 → first 15 committed, len_err pulse after word 15, words 16–17 dropped. Following 15-word vector delivered intact.
- Reset mid-operation: one full bank held plus 7 words written, then rst_n=0 for 1 cycle → m_valid=0, all banks empty. Next 15-word vector delivered with slice 0 = its first word.
